// File: rtl/wbuffer_drain_if.sv
// rtl/wbuffer_drain_if.sv - store push and memory drain handshake bundle for the write buffer
interface wbuffer_drain_if;
   logic        push_valid;
   logic        push_ready;
   logic [31:0] push_addr;
   logic [3:0]  push_wstrb;
   logic [31:0] push_data;
   logic        mem_req;
   logic        mem_ack;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;

   modport master (
      output push_valid, push_addr, push_wstrb, push_data, mem_ack,
      input  push_ready, mem_req, mem_addr, mem_wstrb, mem_wdata
   );

   modport slave (
      input  push_valid, push_addr, push_wstrb, push_data, mem_ack,
      output push_ready, mem_req, mem_addr, mem_wstrb, mem_wdata
   );
endinterface

// File: rtl/wbuffer_drain.sv
// rtl/wbuffer_drain.sv - data cache write buffer: circular store queue drained in order to memory
module wbuffer_drain #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   wbuffer_drain_if.slave        bus,
   input  logic [31:0]           lk_addr,
   output logic                  lk_hit,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, RD, REQ} state_t;

   state_t                  state, state_nxt;
   logic [DEPTH_LOG2-1:0]   head, tail;
   logic [DEPTH-1:0]        valid;
   logic [29:0]             ent_addr  [DEPTH];
   logic [3:0]              ent_wstrb [DEPTH];
   logic [31:0]             ent_data  [DEPTH];
   logic [31:0]             rd_data;
   logic                    push_fire, pop_fire;
   logic [DEPTH_LOG2:0]     count_nxt;
   logic [3:0]              unused_bits;

   assign unused_bits   = {bus.push_addr[1:0], lk_addr[1:0]};

   assign full          = (count == (DEPTH_LOG2+1)'(DEPTH));
   assign empty         = (count == '0);
   assign bus.push_ready = !full;
   assign push_fire     = bus.push_valid && !full;
   assign pop_fire      = (state == REQ) && bus.mem_ack;

   always_comb begin
      count_nxt = count;
      case ({push_fire, pop_fire})
         2'b10:   count_nxt = count + (DEPTH_LOG2+1)'(1);
         2'b01:   count_nxt = count - (DEPTH_LOG2+1)'(1);
         default: count_nxt = count;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (count != '0) state_nxt = RD;
         RD:      state_nxt = REQ;
         REQ:     if (pop_fire) state_nxt = (count_nxt != '0) ? RD : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (push_fire) tail <= tail + (DEPTH_LOG2)'(1);
         if (pop_fire)  head <= head + (DEPTH_LOG2)'(1);
         // head and tail never coincide on a cycle that both pushes and pops
         if (pop_fire)  valid[head] <= 1'b0;
         if (push_fire) valid[tail] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push_fire) begin
         ent_addr[tail]  <= bus.push_addr[31:2];
         ent_wstrb[tail] <= bus.push_wstrb;
      end
   end

   // Data storage: synchronous write, registered read issued only in RD
   always_ff @(posedge clk) begin
      if (!rst && push_fire) ent_data[tail] <= bus.push_data;
      if (state == RD)       rd_data <= ent_data[head];
   end

   assign bus.mem_req   = (state == REQ);
   assign bus.mem_addr  = (state == REQ) ? {ent_addr[head], 2'b00} : '0;
   assign bus.mem_wstrb = (state == REQ) ? ent_wstrb[head] : '0;
   assign bus.mem_wdata = rd_data;

   always_comb begin
      lk_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && (ent_addr[i] == lk_addr[31:2])) lk_hit = 1'b1;
      end
   end
endmodule

// File: tb/tb_wbuffer_drain.sv
// tb/tb_wbuffer_drain.sv - self-checking bench for wbuffer_drain against a queue model
module tb_wbuffer_drain;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] lk_addr;
   logic        lk_hit;
   logic [4:0]  count;
   logic        empty, full;

   always #5 clk = ~clk;

   wbuffer_drain_if bus();

   wbuffer_drain #(.DEPTH_LOG2(4)) dut (
      .clk(clk), .rst(rst), .bus(bus), .lk_addr(lk_addr),
      .lk_hit(lk_hit), .count(count), .empty(empty), .full(full)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic [31:0] addr;
      logic        hit;
   } lk_vec_t;

   ent_t        q[$];
   logic [31:0] drained_data[$];
   logic [3:0]  drained_strb[$];
   int          ack_cyc[$];
   int          checks = 0;
   int          errors = 0;
   int          stall = 0;
   int          cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic model_hit(input logic [31:0] a);
      foreach (q[i]) if (q[i].addr[31:2] == a[31:2]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_state();
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == 16));
      chk("push_ready", 32'(bus.push_ready), 32'(q.size() != 16));
      chk("lk_hit", 32'(lk_hit), 32'(model_hit(lk_addr)));
      if (q.size() > 0 && !bus.mem_req) stall++; else stall = 0;
      chk("drain_stall", 32'(stall <= 2), 32'd1);
      if (bus.mem_req) begin
         chk("req_nonempty", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) begin
            chk("mem_addr", bus.mem_addr, q[0].addr);
            chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(q[0].wstrb));
            chk("mem_wdata", bus.mem_wdata, q[0].data);
         end
      end
   endtask

   // Inputs are set before calling; one rising edge is applied and the model follows it
   task automatic step();
      bit   push_acc, pop;
      ent_t e;
      push_acc = !rst && bus.push_valid && (q.size() < 16);
      pop      = !rst && bus.mem_req && bus.mem_ack;
      e.addr   = {bus.push_addr[31:2], 2'b00};
      e.wstrb  = bus.push_wstrb;
      e.data   = bus.push_data;
      if (pop) begin
         drained_data.push_back(bus.mem_wdata);
         drained_strb.push_back(bus.mem_wstrb);
         ack_cyc.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      if (rst) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (push_acc) q.push_back(e);
      end
      @(negedge clk);
      check_state();
   endtask

   task automatic idle_inputs();
      bus.push_valid = 1'b0;
      bus.push_addr  = '0;
      bus.push_wstrb = '0;
      bus.push_data  = '0;
      bus.mem_ack    = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      drained_data.delete();
      drained_strb.delete();
      ack_cyc.delete();
   endtask

   task automatic push1(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      bus.push_valid = 1'b1;
      bus.push_addr  = a;
      bus.push_wstrb = s;
      bus.push_data  = d;
      step();
      bus.push_valid = 1'b0;
   endtask

   task automatic wait_req();
      for (int k = 0; k < 10 && !bus.mem_req; k++) step();
   endtask

   lk_vec_t lk_tab[6];

   initial begin
      int   pushes, dly, maxc;
      bit   took, both;
      logic [4:0]  prev;
      logic [31:0] sent[$];
      logic [31:0] d;

      lk_tab[0] = '{addr: 32'h0000_200B, hit: 1'b1};
      lk_tab[1] = '{addr: 32'h0000_200C, hit: 1'b0};
      lk_tab[2] = '{addr: 32'h0000_2008, hit: 1'b1};
      lk_tab[3] = '{addr: 32'h0000_2004, hit: 1'b0};
      lk_tab[4] = '{addr: 32'h0000_2009, hit: 1'b1};
      lk_tab[5] = '{addr: 32'h8000_2008, hit: 1'b0};

      lk_addr = '0;
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);

      // reset state and single store latency
      do_reset();
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
      push1(32'h0000_1004, 4'hF, 32'hDEAD_BEEF);
      chk("t1_e0_count", 32'(count), 32'd1);
      chk("t1_e0_req", 32'(bus.mem_req), 32'd0);
      step();
      chk("t1_e1_req", 32'(bus.mem_req), 32'd0);
      step();
      chk("t1_e2_req", 32'(bus.mem_req), 32'd1);
      chk("t1_addr", bus.mem_addr, 32'h0000_1004);
      chk("t1_strb", 32'(bus.mem_wstrb), 32'hF);
      chk("t1_data", bus.mem_wdata, 32'hDEAD_BEEF);
      step();
      step();
      chk("t1_hold_req", 32'(bus.mem_req), 32'd1);
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
      chk("t1_done_count", 32'(count), 32'd0);
      chk("t1_done_empty", 32'(empty), 32'd1);

      // fill to 16, reject a 17th, then drain with ack always high
      do_reset();
      for (int i = 0; i < 16; i++) push1(32'h100 + 32'(4 * i), 4'hF, 32'(i));
      chk("t2_full", 32'(full), 32'd1);
      chk("t2_ready", 32'(bus.push_ready), 32'd0);
      chk("t2_count", 32'(count), 32'd16);
      push1(32'h500, 4'hF, 32'd99);
      chk("t2_17th_count", 32'(count), 32'd16);
      bus.mem_ack = 1'b1;
      for (int k = 0; k < 40 && q.size() > 0; k++) step();
      bus.mem_ack = 1'b0;
      chk("t2_drained", 32'(drained_data.size()), 32'd16);
      foreach (drained_data[i]) chk("t2_order", drained_data[i], 32'(i));
      for (int i = 1; i < ack_cyc.size(); i++) chk("t2_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd2);

      // random pushes with random ack delay, pointers wrap several times
      do_reset();
      pushes = 0; dly = $urandom_range(0, 3); maxc = 0;
      for (int c = 0; c < 2000 && !(pushes == 48 && q.size() == 0); c++) begin
         bus.push_valid = (pushes < 48) && (q.size() < 8 || $urandom_range(0, 3) == 0);
         bus.push_addr  = $urandom;
         bus.push_wstrb = 4'($urandom);
         d              = $urandom;
         bus.push_data  = d;
         if (q.size() > 0 && $urandom_range(0, 1) == 1)
            lk_addr = q[$urandom_range(0, q.size() - 1)].addr | 32'($urandom_range(0, 3));
         else
            lk_addr = $urandom;
         took = bus.mem_req && (dly == 0);
         bus.mem_ack = took;
         if (bus.mem_req && dly > 0) dly--;
         both = 1'b0;
         if (bus.push_valid && q.size() < 16) begin
            sent.push_back(d);
            pushes++;
            both = took;
         end
         prev = count;
         step();
         if (both) chk("t3_both_count", 32'(count), 32'(prev));
         if (int'(count) > maxc) maxc = int'(count);
         if (took) dly = $urandom_range(0, 3);
      end
      idle_inputs();
      lk_addr = '0;
      chk("t3_drained", 32'(drained_data.size()), 32'(sent.size()));
      foreach (drained_data[i]) if (i < sent.size()) chk("t3_order", drained_data[i], sent[i]);
      chk("t3_max_count", 32'(maxc <= 16), 32'd1);

      // load hazard against a pending entry
      do_reset();
      push1(32'h0000_2008, 4'hF, 32'h1);
      for (int i = 0; i < 6; i++) begin
         lk_addr = lk_tab[i].addr;
         #1;
         chk("t4_lk_tab", 32'(lk_hit), 32'(lk_tab[i].hit));
      end
      lk_addr = 32'h0000_200B;
      wait_req();
      chk("t4_req", 32'(bus.mem_req), 32'd1);
      chk("t4_hit_req", 32'(lk_hit), 32'd1);
      step();
      chk("t4_hit_hold", 32'(lk_hit), 32'd1);
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
      chk("t4_hit_after_ack", 32'(lk_hit), 32'd0);
      lk_addr = '0;

      // reset while a request is outstanding, with ack in the same cycle
      do_reset();
      for (int i = 0; i < 5; i++) push1(32'h4000 + 32'(4 * i), 4'hF, 32'(100 + i));
      wait_req();
      chk("t5_req", 32'(bus.mem_req), 32'd1);
      rst = 1'b1;
      bus.mem_ack = 1'b1;
      step();
      rst = 1'b0;
      bus.mem_ack = 1'b0;
      chk("t5_req_after", 32'(bus.mem_req), 32'd0);
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_empty", 32'(empty), 32'd1);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("t5_no_req", 32'(bus.mem_req), 32'd0);
      end

      // same address with different strobes drains as two requests
      do_reset();
      push1(32'h0000_3000, 4'h3, 32'hA);
      push1(32'h0000_3000, 4'hC, 32'hB);
      bus.mem_ack = 1'b1;
      for (int k = 0; k < 20 && drained_strb.size() < 2; k++) step();
      bus.mem_ack = 1'b0;
      chk("t6_nreq", 32'(drained_strb.size()), 32'd2);
      if (drained_strb.size() >= 2) begin
         chk("t6_strb0", 32'(drained_strb[0]), 32'h3);
         chk("t6_strb1", 32'(drained_strb[1]), 32'hC);
         chk("t6_data0", drained_data[0], 32'hA);
         chk("t6_data1", drained_data[1], 32'hB);
      end
      step();
      chk("t6_empty", 32'(empty), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
